rom_bank_fetch_ctrl: RTL and testbench

Sequencer for the conv-layer weight ROM bank: NUM parallel 1k x 16 ROMs, one per output channel. On a start pulse it sweeps a common read address 0..num_words-1 across all selected banks. It drives the per-bank enables and the broadcast address, honours a downstream stall, and emits a valid strobe aligned with the ROMs' registered 1-cycle read data. It sits between the layer controller and the ROM bank; the MAC array consumes rom data when valid_out=1.

---
 rtl/rom_bank_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_rom_bank_fetch_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_bank_fetch_ctrl.sv
// Read sequencer for the conv-layer weight ROM bank.
// A start pulse launches a sweep of a shared read address from 0 to
// num_words-1 across the selected banks. A downstream stall pauses the
// sweep. valid_out/last_out line up with the ROMs' registered 1-cycle read
// data, and done fires once in the drain cycle.
module rom_bank_fetch_ctrl #(
  parameter int NUM    = 10,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W:0]         num_words,
  input  logic [NUM-1:0]          bank_mask,
  input  logic                    stall,
  input  logic                    abort,
  output logic [NUM-1:0]          en,
  output logic [NUM*ADDR_W-1:0]   addr_master,
  output logic                    valid_out,
  output logic                    last_out,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_W   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_1  = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     num_words_q, num_words_d;
  logic [NUM-1:0]      mask_q, mask_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  logic                start_ok;
  logic                issue;
  logic                at_last;
  logic [ADDR_W:0]     last_word;

  // A start counts only with a word count in 1..DEPTH. An abort in the
  // same cycle overrides it.
  assign start_ok  = start && !abort && (num_words != '0) && (num_words <= DEPTH_W);
  // A read goes to the ROMs in every un-stalled FETCH cycle.
  assign issue     = (state_q == FETCH) && !stall;
  assign last_word = num_words_q - ONE_W;
  assign at_last   = ({1'b0, addr_q} == last_word);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then updates from values sampled before the edge.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment first means every path drives state_d,
    // so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = FETCH;
      FETCH:   if (abort) state_d = IDLE;
               else if (issue && at_last) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: sweep parameters, address counter and the read-data qualifiers.
  always_comb begin
    addr_d      = addr_q;
    num_words_d = num_words_q;
    mask_d      = mask_q;
    valid_d     = issue && !abort;
    last_d      = issue && at_last && !abort;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          addr_d      = '0;
          num_words_d = num_words;
          mask_d      = bank_mask;
        end
      end
      FETCH: begin
        if (abort)                   addr_d = '0;
        else if (issue && !at_last)  addr_d = addr_q + ADDR_1;
      end
      DRAIN:   addr_d = '0;
      default: addr_d = '0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      num_words_q <= '0;
      mask_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      num_words_q <= num_words_d;
      mask_q      <= mask_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  // Outputs. en follows stall combinationally, so a stalled cycle issues no read.
  always_comb begin
    en          = issue ? mask_q : '0;
    addr_master = {NUM{addr_q}};
    valid_out   = valid_q;
    last_out    = last_q;
    busy        = (state_q != IDLE);
    done        = (state_q == DRAIN);
  end

endmodule

// File: tb/tb_rom_bank_fetch_ctrl.sv
// Self-checking bench for rom_bank_fetch_ctrl.
// Each cycle vector has inputs and the outputs expected in that same cycle.
// The vector is queued when its inputs are driven, then popped and compared
// at the falling edge. Full-depth sweeps and async reset are coded by hand.
module tb_rom_bank_fetch_ctrl;

  localparam int NUM    = 10;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [ADDR_W:0]       num_words;
  logic [NUM-1:0]        bank_mask;
  logic                  stall;
  logic                  abort;
  logic [NUM-1:0]        en;
  logic [NUM*ADDR_W-1:0] addr_master;
  logic                  valid_out;
  logic                  last_out;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic              start;
    logic [ADDR_W:0]   nw;
    logic [NUM-1:0]    mask;
    logic              stall;
    logic              abort;
    logic [NUM-1:0]    x_en;
    logic [ADDR_W-1:0] x_addr;
    logic              x_valid;
    logic              x_last;
    logic              x_busy;
    logic              x_done;
  } vec_t;

  vec_t exp_q[$];

  rom_bank_fetch_ctrl #(.NUM(NUM), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_words   (num_words),
    .bank_mask   (bank_mask),
    .stall       (stall),
    .abort       (abort),
    .en          (en),
    .addr_master (addr_master),
    .valid_out   (valid_out),
    .last_out    (last_out),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic st, input int nw, input logic [NUM-1:0] m,
                               input logic sl, input logic ab, input logic [NUM-1:0] e,
                               input int a, input logic vo, input logic lo,
                               input logic b, input logic d);
    vec_t v;
    v.start = st;  v.nw = (ADDR_W+1)'(nw); v.mask = m; v.stall = sl; v.abort = ab;
    v.x_en = e;    v.x_addr = ADDR_W'(a);  v.x_valid = vo; v.x_last = lo;
    v.x_busy = b;  v.x_done = d;
    return v;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; num_words = '0; bank_mask = '0; stall = 1'b0; abort = 1'b0;
  endtask

  // Drive one vector, queue its expectation, compare at the falling edge,
  // then advance to just after the next rising edge.
  task automatic step(input vec_t v, input string tag);
    vec_t g;
    start = v.start; num_words = v.nw; bank_mask = v.mask; stall = v.stall; abort = v.abort;
    exp_q.push_back(v);
    @(negedge clk);
    g = exp_q.pop_front();
    check({tag, " ctl"}, {118'b0, en, valid_out, last_out, busy, done},
          {118'b0, g.x_en, g.x_valid, g.x_last, g.x_busy, g.x_done});
    check({tag, " addr"}, {28'b0, addr_master}, {28'b0, {NUM{g.x_addr}}});
    @(posedge clk); #1;
  endtask

  task automatic run_table(input vec_t t[$], input string nm);
    foreach (t[i]) step(t[i], $sformatf("%s[%0d]", nm, i));
    idle_inputs();
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " ctl"}, {118'b0, en, valid_out, last_out, busy, done}, 128'b0);
    check({nm, " addr"}, {28'b0, addr_master}, 128'b0);
  endtask

  localparam logic [NUM-1:0] ALL = '1;

  vec_t basic[$], stl[$], msk[$], ill[$], abt[$], drn[$], zm[$], pre[$];

  initial begin
    // start, nw, mask, stall, abort | en, addr, valid, last, busy, done
    basic = '{
      mkv(1, 4, ALL, 0, 0, '0,  0, 0, 0, 0, 0),
      mkv(0, 0, '0,  0, 0, ALL, 0, 0, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, ALL, 1, 1, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, ALL, 2, 1, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, ALL, 3, 1, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, '0,  3, 1, 1, 1, 1),
      mkv(0, 0, '0,  0, 0, '0,  0, 0, 0, 0, 0)
    };
    stl = '{
      mkv(1, 3, ALL, 0, 0, '0,  0, 0, 0, 0, 0),
      mkv(0, 0, '0,  0, 0, ALL, 0, 0, 0, 1, 0),
      mkv(0, 0, '0,  1, 0, '0,  1, 1, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, ALL, 1, 0, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, ALL, 2, 1, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, '0,  2, 1, 1, 1, 1),
      mkv(0, 0, '0,  0, 0, '0,  0, 0, 0, 0, 0)
    };
    // Mask 0b101, plus a second start while busy that must be ignored.
    msk = '{
      mkv(1, 2, 10'h005, 0, 0, '0,      0, 0, 0, 0, 0),
      mkv(1, 5, ALL,     0, 0, 10'h005, 0, 0, 0, 1, 0),
      mkv(0, 0, '0,      0, 0, 10'h005, 1, 1, 0, 1, 0),
      mkv(0, 0, '0,      0, 0, '0,      1, 1, 1, 1, 1),
      mkv(0, 0, '0,      0, 0, '0,      0, 0, 0, 0, 0)
    };
    // num_words 0, num_words 1025, and start together with abort.
    ill = '{
      mkv(1, 0,    ALL, 0, 0, '0, 0, 0, 0, 0, 0),
      mkv(0, 0,    '0,  0, 0, '0, 0, 0, 0, 0, 0),
      mkv(1, 1025, ALL, 0, 0, '0, 0, 0, 0, 0, 0),
      mkv(0, 0,    '0,  0, 0, '0, 0, 0, 0, 0, 0),
      mkv(1, 2,    ALL, 0, 1, '0, 0, 0, 0, 0, 0),
      mkv(0, 0,    '0,  0, 0, '0, 0, 0, 0, 0, 0)
    };
    abt = '{
      mkv(1, 8, ALL, 0, 0, '0,  0, 0, 0, 0, 0),
      mkv(0, 0, '0,  0, 0, ALL, 0, 0, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, ALL, 1, 1, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, ALL, 2, 1, 0, 1, 0),
      mkv(0, 0, '0,  0, 1, ALL, 3, 1, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, '0,  0, 0, 0, 0, 0),
      mkv(0, 0, '0,  0, 0, '0,  0, 0, 0, 0, 0),
      mkv(1, 2, ALL, 0, 0, '0,  0, 0, 0, 0, 0),
      mkv(0, 0, '0,  0, 0, ALL, 0, 0, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, ALL, 1, 1, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, '0,  1, 1, 1, 1, 1),
      mkv(0, 0, '0,  0, 0, '0,  0, 0, 0, 0, 0)
    };
    // Single-word sweep with stall held during DRAIN.
    drn = '{
      mkv(1, 1, ALL, 0, 0, '0,  0, 0, 0, 0, 0),
      mkv(0, 0, '0,  0, 0, ALL, 0, 0, 0, 1, 0),
      mkv(0, 0, '0,  1, 0, '0,  0, 1, 1, 1, 1),
      mkv(0, 0, '0,  0, 0, '0,  0, 0, 0, 0, 0)
    };
    // All-zero mask: no enables, but valid, last and done keep their timing.
    zm = '{
      mkv(1, 2, '0, 0, 0, '0, 0, 0, 0, 0, 0),
      mkv(0, 0, '0, 0, 0, '0, 0, 0, 0, 1, 0),
      mkv(0, 0, '0, 0, 0, '0, 1, 1, 0, 1, 0),
      mkv(0, 0, '0, 0, 0, '0, 1, 1, 1, 1, 1),
      mkv(0, 0, '0, 0, 0, '0, 0, 0, 0, 0, 0)
    };
    // Start of a sweep that async reset cuts off.
    pre = '{
      mkv(1, 8, ALL, 0, 0, '0,  0, 0, 0, 0, 0),
      mkv(0, 0, '0,  0, 0, ALL, 0, 0, 0, 1, 0),
      mkv(0, 0, '0,  0, 0, ALL, 1, 1, 0, 1, 0)
    };

    // Reset state.
    rst_n = 1'b0;
    idle_inputs();
    #3;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_table(basic, "basic");
    run_table(stl,   "stall");
    run_table(msk,   "mask");
    run_table(ill,   "illegal");
    run_table(abt,   "abort");
    run_table(drn,   "drain_stall");
    run_table(zm,    "zero_mask");

    // Full-depth sweep: addresses 0..1023 in order, no wrap, done at cycle 1025.
    begin
      int issued, vcount, done_cyc, last_issued;
      issued = 0; vcount = 0; done_cyc = 0; last_issued = -1;
      step(mkv(1, DEPTH, ALL, 0, 0, '0, 0, 0, 0, 0, 0), "full start");
      idle_inputs();
      for (int j = 1; j <= 1100; j++) begin
        @(negedge clk);
        if (en !== '0) begin
          check("full addr", {118'b0, addr_master[ADDR_W-1:0]}, 128'(issued));
          last_issued = int'(addr_master[ADDR_W-1:0]);
          issued++;
        end
        if (valid_out === 1'b1) vcount++;
        if (done === 1'b1) begin
          done_cyc = j;
          check("full last_out", {127'b0, last_out}, 128'd1);
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
      end
      check("full done latency", 128'(done_cyc), 128'd1025);
      check("full reads issued", 128'(issued), 128'd1024);
      check("full final addr",   128'(last_issued), 128'd1023);
      check("full valid count",  128'(vcount), 128'd1024);
      @(negedge clk);
      check_all_zero("full after");
      @(posedge clk); #1;
    end

    // Async reset between clock edges while valid_out is high.
    run_table(pre, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_table(basic, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
